ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes latched operands (regfile_out1_out, regfile_out2_out) and decoded mult/div/MTHI/MTLO controls.
- Raises busy so hazard logic stalls ID/EX while an operation is in flight. HI/LO feed the LHToReg write-back mux.

Parameters:
- DATA_BITS, 32, operand/result width (HI and LO each DATA_BITS).
- CNT_BITS, 6, iteration counter width; must hold DATA_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch operation this cycle (EX holds a mult/div instruction).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  DATA_BITS  operand rs (dividend / multiplicand).
- b  input  DATA_BITS  operand rt (divisor / multiplier).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  DATA_BITS  MTHI/MTLO data.
- flush  input  1  cancel in-flight operation (same source as ID/EX zero).
- busy  output  1  operation in flight; HI/LO not valid for read.
- done  output  1  one-cycle pulse, HI/LO just updated by an operation.
- div_zero  output  1  sticky: last DIV/DIVU had b==0; cleared by next start.
- hi  output  DATA_BITS  HI register.
- lo  output  DATA_BITS  LO register.

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, internal datapath regs=0.
- States: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE:
  - start=1 at edge E0 → capture |a|,|b| (signed ops) or raw a,b (unsigned), record result signs, counter=0, go to CALC.
  - If start=0, hi_we/lo_we write wdata to hi/lo at the edge.
  - If start, hi_we and lo_we are all asserted at E0, the write takes effect and the operation result later overwrites it.
- CALC:
  - One iteration per edge: shift-add multiply (64-bit product) or restoring divide (1 quotient bit per edge).
  - Counter increments. After the edge where counter reaches DATA_BITS-1 (edge E32), go to FIX.
- FIX (edge E33):
  - Apply sign fix-up. Multiply: negate the 64-bit product if signs differ. Divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo (product upper/lower; remainder/quotient), assert done for the following cycle, go to IDLE.
- Latency: busy high for exactly 33 cycles after the start edge. New hi/lo visible in the cycle done is high.
- Start while busy: ignored; no queueing.
- hi_we/lo_we while busy: discarded. Hazard logic must stall them behind busy.
- Divide by zero:
  - Iterations run normally.
  - FIX forces lo=all ones and hi=a (original operand), and sets div_zero.
  - Applies to both DIV and DIVU.
- Signed overflow case: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural two's-complement wrap, no trap).
- flush=1:
  - In CALC or FIX: go to IDLE at the edge; hi/lo/div_zero unchanged; no done pulse.
  - In IDLE: suppresses start and hi_we/lo_we that cycle.
- Reset mid-operation: immediate IDLE with all outputs zeroed; no done.
- done is never high in two consecutive cycles. busy and done are never both high.

Decomposition:
- Shared package:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state encodings (ST_IDLE, ST_CALC, ST_FIX);
  - DATA_BITS default;
  - divide-by-zero LO constant.
- One natural sub-module, muldiv_iter: the per-cycle shift/add/subtract step (combinational next-value of the accumulator/quotient pair given op class). The FSM, counter, sign handling and HI/LO live in ex_muldiv.

Test Plan:
- MULTU a=7, b=6 → busy high 33 cycles, done pulses once, hi=0x00000000, lo=0x0000002A.
- MULT a=0xFFFFFFF9 (-7), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. MULTU on the same operands → hi=0x00000005, lo=0xFFFFFFD6.
- DIV a=0xFFFFFF9C (-100), b=7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=0x00000005, div_zero=1. Next MULTU start clears div_zero.
- Preload via MTHI 0x11 and MTLO 0x22. Start MULTU 7×6, assert flush on cycle 10 → busy low next cycle, no done, hi=0x11, lo=0x22. A hi_we pulse while busy leaves hi unchanged.
- Start DIV, assert rst asynchronously mid-CALC (between edges) → busy, done, hi, lo drop to 0 immediately. start accepted on the first edge after rst deasserts.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and constants for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned DEF_DATA_BITS = 32;
  localparam int unsigned DEF_CNT_BITS  = 6;

  // HI/LO instruction classes as decoded by ID.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // LO value reported for a division by zero.
  localparam logic [DEF_DATA_BITS-1:0] DIV0_LO = '1;

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage control and the mul/div unit.
interface ex_muldiv_if #(
  parameter int unsigned DATA_BITS = ex_muldiv_pkg::DEF_DATA_BITS
) ();

  logic                  start;
  ex_muldiv_pkg::op_e    op;
  logic [DATA_BITS-1:0]  a;
  logic [DATA_BITS-1:0]  b;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_BITS-1:0]  wdata;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [DATA_BITS-1:0]  hi;
  logic [DATA_BITS-1:0]  lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, flush,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/ex_muldiv_iter.sv
// One iteration of unsigned shift-add multiply or restoring divide on the
// {upper, lower} accumulator pair.
module muldiv_iter #(
  parameter int unsigned DATA_BITS = ex_muldiv_pkg::DEF_DATA_BITS
) (
  input  logic                     is_div_i,
  input  logic [DATA_BITS-1:0]     opnd_i,
  input  logic [2*DATA_BITS-1:0]   acc_i,
  output logic [2*DATA_BITS-1:0]   acc_o
);

  localparam int unsigned W  = DATA_BITS;
  localparam int unsigned AW = 2 * DATA_BITS;

  logic [W:0]   mul_sum_c;
  logic [W:0]   rem_sh_c;
  logic [W:0]   rem_full_c;
  logic         q_bit_c;

  // Multiply: add multiplicand into upper half on LSB, shift right.
  // Divide: shift left, trial-subtract divisor, keep difference if non-negative.
  always_comb begin
    mul_sum_c  = {1'b0, acc_i[AW-1:W]};
    if (acc_i[0]) begin
      mul_sum_c = mul_sum_c + {1'b0, opnd_i};
    end
    rem_sh_c   = acc_i[AW-1:W-1];
    q_bit_c    = (rem_sh_c >= {1'b0, opnd_i});
    rem_full_c = q_bit_c ? (rem_sh_c - {1'b0, opnd_i}) : rem_sh_c;
    if (is_div_i) begin
      acc_o = {W'(rem_full_c), acc_i[W-2:0], q_bit_c};
    end else begin
      acc_o = {mul_sum_c, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit holding the architectural HI/LO
// registers; 32 iterations plus a sign fix-up cycle per operation.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned CNT_BITS  = DEF_CNT_BITS
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam int unsigned W  = DATA_BITS;
  localparam int unsigned AW = 2 * DATA_BITS;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DATA_BITS - 1);

  state_e              state_q;
  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       acc_d;
  logic [W-1:0]        opnd_q;
  logic [W-1:0]        a_orig_q;
  logic [W-1:0]        hi_q;
  logic [W-1:0]        lo_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                is_div_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic                b_zero_q;
  logic                busy_q;
  logic                done_q;
  logic                div_zero_q;

  logic                is_div_c;
  logic                is_signed_c;
  logic                a_neg_c;
  logic                b_neg_c;
  logic [W-1:0]        a_abs_c;
  logic [W-1:0]        b_abs_c;
  logic [AW-1:0]       prod_c;
  logic [W-1:0]        quot_c;
  logic [W-1:0]        rem_c;

  // Operand decode: magnitudes for signed ops, raw values for unsigned.
  always_comb begin
    is_div_c    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg_c     = is_signed_c & bus.a[W-1];
    b_neg_c     = is_signed_c & bus.b[W-1];
    a_abs_c     = a_neg_c ? (W'(0) - bus.a) : bus.a;
    b_abs_c     = b_neg_c ? (W'(0) - bus.b) : bus.b;
  end

  // Sign fix-up of the finished unsigned result; remainder follows dividend.
  always_comb begin
    prod_c = neg_res_q ? (AW'(0) - acc_q) : acc_q;
    quot_c = neg_res_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
    rem_c  = neg_rem_q ? (W'(0) - acc_q[AW-1:W]) : acc_q[AW-1:W];
  end

  muldiv_iter #(
    .DATA_BITS (DATA_BITS)
  ) u_iter (
    .is_div_i (is_div_q),
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .acc_o    (acc_d)
  );

  // Control FSM, iteration counter and HI/LO register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_orig_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!bus.flush) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
            if (bus.start) begin
              state_q    <= ST_CALC;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              div_zero_q <= 1'b0;
              is_div_q   <= is_div_c;
              neg_res_q  <= a_neg_c ^ b_neg_c;
              neg_rem_q  <= a_neg_c;
              b_zero_q   <= (bus.b == '0);
              a_orig_q   <= bus.a;
              if (is_div_c) begin
                opnd_q <= b_abs_c;
                acc_q  <= {W'(0), a_abs_c};
              end else begin
                opnd_q <= a_abs_c;
                acc_q  <= {W'(0), b_abs_c};
              end
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div_q && b_zero_q) begin
              hi_q       <= a_orig_q;
              lo_q       <= DIV0_LO;
              div_zero_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem_c;
              lo_q <= quot_c;
            end else begin
              hi_q <= prod_c[AW-1:W];
              lo_q <= prod_c[W-1:0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ex_muldiv_if #(.DATA_BITS(32)) bus ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, count busy cycles, check done pulse and HI/LO.
  // inject: pulse start with other operands mid-flight (must be ignored).
  task automatic run_op(input string tag, input op_e op, input logic [31:0] av,
                        input logic [31:0] bv, input bit inject,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt;
    bus.op    = op;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cnt  = 0;
    while (bus.busy && busy_cnt < 40) begin
      busy_cnt++;
      if (inject && busy_cnt == 3) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd7;
        bus.b     = 32'd6;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    tick();
    check({tag, " done_clear"}, 64'(bus.done), 64'd0);
    check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int c;
    int done_seen;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    bus.flush = 1'b0;

    #12;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    tick();

    run_op("multu_7x6", OP_MULTU, 32'd7, 32'd6, 1'b0, 32'h0000_0000, 32'h0000_002A);
    run_op("mult_m7x6", OP_MULT, 32'hFFFF_FFF9, 32'd6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("multu_big", OP_MULTU, 32'hFFFF_FFF9, 32'd6, 1'b0, 32'h0000_0005, 32'hFFFF_FFD6);
    run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    run_op("divu_100_7_inj", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 32'hFFFF_FFF2);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
    check("div_ovf div_zero", 64'(bus.div_zero), 64'd0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF);
    check("divu_5_0 div_zero", 64'(bus.div_zero), 64'd1);

    // Start with simultaneous MTHI/MTLO: writes land, result overwrites later.
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hAB;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("start_wr div_zero_clear", 64'(bus.div_zero), 64'd0);
    check("start_wr busy", 64'(bus.busy), 64'd1);
    check("start_wr hi", 64'(bus.hi), 64'hAB);
    check("start_wr lo", 64'(bus.lo), 64'hAB);
    c = 0;
    while (bus.busy && c < 40) begin
      c++;
      tick();
    end
    check("start_wr done", 64'(bus.done), 64'd1);
    check("start_wr res hi", 64'(bus.hi), 64'd0);
    check("start_wr res lo", 64'(bus.lo), 64'd15);
    tick();

    // MTHI / MTLO preload.
    bus.hi_we = 1'b1;
    bus.wdata = 32'h11;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h22;
    tick();
    bus.lo_we = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h11);
    check("mtlo lo", 64'(bus.lo), 64'h22);

    // Flush on cycle 10 of a MULTU; a busy-time MTHI must be discarded.
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      bus.hi_we = (i == 5);
      bus.wdata = 32'h99;
      tick();
    end
    bus.hi_we = 1'b0;
    check("flush busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush hi", 64'(bus.hi), 64'h11);
    check("flush lo", 64'(bus.lo), 64'h22);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("flush no_done", 64'(done_seen), 64'd0);
    check("flush hi_late", 64'(bus.hi), 64'h11);

    // Flush in IDLE suppresses both start and MTHI.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h55;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    check("idle_flush busy", 64'(bus.busy), 64'd0);
    check("idle_flush hi", 64'(bus.hi), 64'h11);

    // Asynchronous reset mid-CALC.
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'hFFFF_FF9C;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", 64'(bus.busy), 64'd0);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst hi", 64'(bus.hi), 64'd0);
    check("arst lo", 64'(bus.lo), 64'd0);
    #3;
    rst = 1'b0;
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    tick();
    bus.start = 1'b0;
    check("post_rst start busy", 64'(bus.busy), 64'd1);
    c = 0;
    while (bus.busy && c < 40) begin
      c++;
      tick();
    end
    check("post_rst done", 64'(bus.done), 64'd1);
    check("post_rst lo", 64'(bus.lo), 64'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
